// File: rtl/dice_roll_controller.sv
// Dice roll sequencer: debounces the roll button, tumbles faces 1..6 while the
// button is held, decelerates over SLOW_STEPS steps after release, then holds
// the result.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn        raw asynchronous roll button, active-high
//   lamp_test  forces dice_value to 7 without disturbing the sequencer
//   dice_value face code to the pip encoder (0 blank, 1..6 faces, 7 lamp test)
//   rolling    high while tumbling or decelerating
//   done       one-cycle pulse when the final face is first shown
module dice_roll_controller #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned TICK_DIV   = 8,
    parameter int unsigned SLOW_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       lamp_test,
    output logic [2:0] dice_value,
    output logic       rolling,
    output logic       done
);

    // Longest interval is the last deceleration step: TICK_DIV << (SLOW_STEPS-1).
    localparam int unsigned MAX_INTERVAL = TICK_DIV << (SLOW_STEPS - 1);
    localparam int unsigned TICK_W       = $clog2(MAX_INTERVAL + 1);
    localparam int unsigned K_W          = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;
    localparam int unsigned DB_W         = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [2:0]  LAMP_CODE    = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SLOW = 2'd2,
        SHOW = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        sync_q;
    logic              btn_sync;
    logic [DB_W-1:0]   db_cnt;
    logic              btn_db;
    logic              btn_db_d;
    logic              press_c;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic [K_W-1:0]    step_k;
    logic [K_W-1:0]    k_next;
    logic [2:0]        face;
    logic [2:0]        face_next;
    logic              rolling_next;
    logic              done_next;
    logic [TICK_W-1:0] slow_limit;
    logic              roll_wrap;
    logic              last_step;

    // Face advance 1..6 with wrap; a blank register starts at 1.
    function automatic logic [2:0] next_face(input logic [2:0] f);
        next_face = (f >= 3'd6) ? 3'd1 : f + 3'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign btn_sync = sync_q[1];

    // Debounce: adopt the synchronised level after DB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_sync != btn_db) begin
                if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    btn_db <= btn_sync;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press_c = btn_db & ~btn_db_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            step_k   <= '0;
            face     <= '0;
            rolling  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            step_k   <= k_next;
            face     <= face_next;
            rolling  <= rolling_next;
            done     <= done_next;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_next   = state;
        tick_next    = tick_cnt;
        k_next       = step_k;
        face_next    = face;
        slow_limit   = TICK_W'((32'(TICK_DIV) << step_k) - 32'd1);
        roll_wrap    = (tick_cnt == TICK_W'(TICK_DIV - 1));
        last_step    = (step_k == K_W'(SLOW_STEPS - 1));

        case (state)
            IDLE: begin
                face_next = '0;
                if (press_c) begin
                    state_next = ROLL;
                    tick_next  = '0;
                end
            end
            ROLL: begin
                if (roll_wrap) begin
                    tick_next = '0;
                    face_next = next_face(face);
                end else begin
                    tick_next = tick_cnt + TICK_W'(1);
                end
                // Release wins over the tick restart, but a coinciding step is kept.
                if (!btn_db) begin
                    state_next = SLOW;
                    k_next     = '0;
                    tick_next  = '0;
                end
            end
            SLOW: begin
                if (tick_cnt == slow_limit) begin
                    tick_next = '0;
                    face_next = next_face(face);
                    if (last_step) begin
                        state_next = SHOW;
                    end else begin
                        k_next = step_k + K_W'(1);
                    end
                end else begin
                    tick_next = tick_cnt + TICK_W'(1);
                end
            end
            SHOW: begin
                if (press_c) begin
                    state_next = ROLL;
                    tick_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rolling_next = (state_next == ROLL) || (state_next == SLOW);
        done_next    = (state_next == SHOW) && (state != SHOW);
    end

    // Lamp test overrides only the displayed code.
    assign dice_value = lamp_test ? LAMP_CODE : face;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Self-checking bench for dice_roll_controller: a timeline-based model of the
// roll behaviour is compared against the DUT every cycle, plus literal checks.
module tb_dice_roll_controller;

    localparam int DB   = 4;
    localparam int TICK = 8;
    localparam int NSLW = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn       = 1'b0;
    logic       lamp_test = 1'b0;
    logic [2:0] dice_value;
    logic       rolling;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cyc  = 0;

    dice_roll_controller #(
        .DB_CYCLES (DB),
        .TICK_DIV  (TICK),
        .SLOW_STEPS(NSLW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .lamp_test (lamp_test),
        .dice_value(dice_value),
        .rolling   (rolling),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 tumbling, 2 decelerating, 3 showing. Steps are scheduled
    // as absolute cycle numbers rather than with a running tick counter.
    int m_mode    = 0;
    int m_face    = 0;
    int m_next    = 0;
    int m_k       = 0;
    int m_cyc     = 0;
    bit m_rolling = 0;
    bit m_done    = 0;
    bit m_s1      = 0;
    bit m_s2      = 0;
    bit m_db      = 0;
    bit m_db_prev = 0;
    bit hist[$];

    function automatic int adv(input int f);
        return (f >= 6) ? 1 : f + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_face = 0; m_next = 0; m_k = 0;
        m_rolling = 0; m_done = 0;
        m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0;
        hist.delete();
    endtask

    task automatic model_edge();
        bit pressed;
        bit all_diff;
        m_cyc++;
        pressed = m_db && !m_db_prev;
        m_done  = 0;
        case (m_mode)
            0: if (pressed) begin m_mode = 1; m_next = m_cyc + TICK; end
            1: begin
                if (m_cyc == m_next) begin m_face = adv(m_face); m_next += TICK; end
                if (!m_db) begin m_mode = 2; m_k = 0; m_next = m_cyc + TICK; end
            end
            2: if (m_cyc == m_next) begin
                m_face = adv(m_face);
                m_k++;
                if (m_k == NSLW) begin m_mode = 3; m_done = 1; end
                else m_next = m_cyc + (TICK << m_k);
            end
            default: if (pressed) begin m_mode = 1; m_next = m_cyc + TICK; end
        endcase
        if (m_mode == 0) m_face = 0;
        m_rolling = (m_mode == 1) || (m_mode == 2);
        // Debounced level flips when the last DB synchronised samples all disagree.
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        all_diff = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == m_db) all_diff = 0;
        m_db_prev = m_db;
        if (all_diff) m_db = !m_db;
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // ---------------- compare + observation ----------------
    int log_face[$];
    int log_cyc[$];
    int last_face  = 0;
    int done_count = 0;
    int done_cyc   = 0;

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            chk("dice_value", int'(dice_value), lamp_test ? 7 : m_face);
            chk("rolling", int'(rolling), int'(m_rolling));
            chk("done", int'(done), int'(m_done));
            if (rst_n && !lamp_test && int'(dice_value) != last_face) begin
                log_face.push_back(int'(dice_value));
                log_cyc.push_back(tb_cyc);
            end
            if (!lamp_test) last_face = int'(dice_value);
            if (done) begin done_count++; done_cyc = tb_cyc; end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        log_face.delete();
        log_cyc.delete();
        done_count = 0;
    endtask

    // ---------------- directed stimulus ----------------
    int p;
    int exp_seq[14] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6, 1, 2};

    initial begin : stim
        cycles(3);
        rst_n = 1'b1;

        // Idle with button released.
        cycles(50);
        chk("idle_dice", int'(dice_value), 0);
        chk("idle_rolling", int'(rolling), 0);
        chk("idle_no_done", done_count, 0);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 6; i++) begin
            btn = 1'b1; cycles(3);
            btn = 1'b0; cycles(3);
        end
        cycles(10);
        chk("bounce_dice", int'(dice_value), 0);
        chk("bounce_rolling", int'(rolling), 0);

        // Ten roll steps, release, press again while slowing down.
        clear_obs();
        p = tb_cyc;
        btn = 1'b1; cycles(83);
        btn = 1'b0; cycles(10);
        btn = 1'b1; cycles(150);
        btn = 1'b0; cycles(20);
        chk("roll1_steps", log_face.size(), 14);
        for (int i = 0; i < 14; i++)
            if (i < log_face.size()) chk("roll1_face_seq", log_face[i], exp_seq[i]);
        if (log_cyc.size() == 14) begin
            chk("roll1_first_step_cyc", log_cyc[0] - p, 15);
            chk("roll1_slow0_cyc", log_cyc[10] - p, 98);
            chk("roll1_slow2_cyc", log_cyc[12] - p, 146);
            chk("roll1_last_cyc", log_cyc[13] - p, 210);
        end
        chk("roll1_done_cyc", done_cyc - p, 210);
        chk("roll1_done_count", done_count, 1);
        chk("roll1_held", int'(dice_value), 2);
        chk("roll1_rolling", int'(rolling), 0);

        // Press from SHOW holding 2, lamp test in the middle of the roll.
        clear_obs();
        p = tb_cyc;
        btn = 1'b1; cycles(30);
        lamp_test = 1'b1; cycles(2);
        chk("lamp_dice", int'(dice_value), 7);
        chk("lamp_rolling", int'(rolling), 1);
        cycles(28);
        lamp_test = 1'b0;
        @(negedge clk);
        chk("lamp_resume_face", int'(dice_value), 2);
        cycles(23);
        btn = 1'b0; cycles(130);
        if (log_face.size() > 0) begin
            chk("roll2_first_face", log_face[0], 3);
            chk("roll2_first_cyc", log_cyc[0] - p, 15);
        end else begin
            chk("roll2_log_empty", 0, 1);
        end
        chk("roll2_held", int'(dice_value), 4);
        chk("roll2_done_cyc", done_cyc - p, 210);
        chk("roll2_done_count", done_count, 1);

        // Reset while decelerating, button held through reset.
        btn = 1'b1; cycles(40);
        btn = 1'b0; cycles(20);
        chk("pre_reset_rolling", int'(rolling), 1);
        btn = 1'b1; cycles(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dice", int'(dice_value), 0);
        chk("async_rst_rolling", int'(rolling), 0);
        chk("async_rst_done", int'(done), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        @(negedge clk);
        chk("post_rst_not_yet", int'(rolling), 0);
        @(negedge clk);
        chk("post_rst_reroll", int'(rolling), 1);
        #2;
        btn = 1'b0;
        cycles(200);
        chk("post_rst_final_rolling", int'(rolling), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_roll_controller.md
Name: dice_roll_controller

Overview:
- Sequences the 3-bit DiceValue that drives the 3x3 pip LED encoder.
- A player button starts a fast "tumble" of faces 1..6 while held; on release the tumble decelerates over a fixed number of steps, then the final face is held.
- Also provides a lamp-test override (code 7, all test pips lit) and a rolling/done status for the top level.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronised samples required before the debounced button changes state.
- TICK_DIV, 8: clock cycles between face steps in ROLL; also the base interval in SLOW.
- SLOW_STEPS, 4: number of decelerating steps after release (range 1..8).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  raw asynchronous roll button, active-high.
- lamp_test  input  1  when high, forces dice_value = 7; state machine unaffected.
- dice_value  output  3  face code to LED encoder (0 = blank, 1..6 faces, 7 = lamp test).
- rolling  output  1  high in ROLL and SLOW.
- done  output  1  one-cycle pulse on entry to SHOW.

Behaviour:
- Reset (async assert, sync release): state IDLE, face register 0, dice_value 0, rolling 0, done 0, debounced button 0, all counters 0.
- Input path:
  - btn passes through a 2-flop synchroniser.
  - btn_db takes the synchronised level once that level has differed from btn_db for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - press = rising edge of btn_db.
- Face step: 0->1, 1->2, ... 5->6, 6->1. Codes 0 and 7 are never stored as a rolled result.
- States:
  - IDLE: face = 0. press -> ROLL with tick counter cleared.
  - ROLL:
    - Tick counter increments every cycle; at TICK_DIV-1 it wraps and the face steps. The first step occurs TICK_DIV cycles after entry.
    - btn_db low -> SLOW with step index k = 0 and tick counter cleared. A step coinciding with release still happens.
  - SLOW:
    - Step k fires after (TICK_DIV << k) cycles, then k increments and the counter clears.
    - After step k = SLOW_STEPS-1 fires -> SHOW.
    - press in SLOW is ignored; a held button does not re-enter ROLL.
  - SHOW:
    - Face held; done = 1 on the first SHOW cycle only.
    - press -> ROLL, stepping from the held face.
- The tick counter is wide enough for TICK_DIV << (SLOW_STEPS-1) with no overflow.
- Output mux: dice_value = 7 if lamp_test, else the face register, combinationally from registered state. rolling and done are registered.
- Reset mid-roll returns to IDLE / blank immediately. A button still held after reset release must be seen as a new press (btn_db resets to 0) and enters ROLL after debounce.

Test Plan:
- Reset then idle 50 cycles with btn = 0 -> dice_value = 0, rolling = 0, done never pulses.
- From IDLE, hold btn clean until exactly 10 ROLL steps have occurred, then release -> ROLL shows 1,2,3,4,5,6,1,2,3,4. SLOW steps after 8, 16, 32 and 64 cycles show 5,6,1,2. SHOW holds 2, done is a single pulse, rolling falls in the same cycle done rises.
- Bounce btn with 3-cycle pulses separated by 3-cycle gaps (below DB_CYCLES = 4) -> btn_db never rises, state stays IDLE, dice_value = 0.
- Press again during SLOW -> ignored, final face unchanged. Release, then press in SHOW holding 2 -> ROLL, first step shows 3 after 8 cycles.
- Assert lamp_test during ROLL -> dice_value = 7 while high, rolling stays 1. Deassert -> the internal face sequence continues uninterrupted, with no skipped or repeated steps.
- Pulse rst_n low during SLOW -> dice_value = 0 and rolling = 0 immediately (asynchronous). With btn held through reset, ROLL is re-entered after synchroniser plus DB_CYCLES latency.
